// File: rtl/csr_timer_stack.sv
// csr_timer_stack: one CSR register, a free-running cycle counter and a LIFO stack
module csr_timer_stack #(
    parameter int          CsrWidth   = 8,
    parameter logic [11:0] Addr       = 12'h300,
    parameter int          ResetValue = 0,
    parameter int          StackDepth = 8,
    parameter int          DataWidth  = 32,
    parameter int          MonoWidth  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            csr_enable,
    input  logic [11:0]                     csr_addr,
    input  logic [2:0]                      csr_op,
    input  logic [4:0]                      rs1_zimm,
    input  logic [31:0]                     rs1_data,
    input  logic                            ext_write_enable,
    input  logic [CsrWidth-1:0]             ext_data,
    output logic [31:0]                     direct_out,
    output logic [31:0]                     out,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DataWidth-1:0]            data_in,
    output logic [DataWidth-1:0]            data_out,
    output logic [$clog2(StackDepth):0]     index_out,
    output logic [MonoWidth-1:0]            mono_timer
);
    localparam int AW = $clog2(StackDepth);
    localparam int IW = AW + 1;

    logic [CsrWidth-1:0]  csr_q;
    logic [31:0]          src;
    logic [31:0]          csr_next;
    logic                 hit;
    logic [DataWidth-1:0] mem [StackDepth];
    logic [IW-1:0]        idx;
    logic [AW-1:0]        top;
    logic                 full;

    // CSR decode: operand select and read-modify-write result on 32 bits
    always_comb begin
        hit        = csr_enable && (csr_addr == Addr);
        direct_out = 32'(csr_q);
        out        = hit ? direct_out : 32'd0;
        src        = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
        csr_next   = csr_op[1:0] == 2'b01 ? src :
                     csr_op[1:0] == 2'b10 ? direct_out | src :
                     csr_op[1:0] == 2'b11 ? direct_out & ~src : direct_out;
    end

    // CSR register: hardware write wins over an instruction write
    always_ff @(posedge clk) begin
        if (reset)
            csr_q <= CsrWidth'(ResetValue);
        else if (ext_write_enable)
            csr_q <= ext_data;
        else if (hit)
            csr_q <= CsrWidth'(csr_next);
    end

    // Free-running counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            mono_timer <= '0;
        else
            mono_timer <= mono_timer + 1'b1;
    end

    // Stack top view; empty stack reads as zero
    always_comb begin
        top       = AW'(idx - 1'b1);
        full      = idx == IW'(StackDepth);
        index_out = idx;
        data_out  = (idx == '0) ? '0 : mem[top];
    end

    // Stack update: push+pop replaces the top, or acts as a push when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (push && pop) begin
            if (idx == '0) begin
                mem[0] <= data_in;
                idx    <= IW'(1);
            end else begin
                mem[top] <= data_in;
            end
        end else if (push && !full) begin
            mem[AW'(idx)] <= data_in;
            idx           <= idx + 1'b1;
        end else if (pop && idx != '0) begin
            idx <= idx - 1'b1;
        end
    end
endmodule

// File: tb/tb_csr_timer_stack.sv
// tb_csr_timer_stack: directed checks of CSR ops, counter and stack
module tb_csr_timer_stack;
    logic        clk = 1'b0;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic        ext_write_enable;
    logic [7:0]  ext_data;
    logic [31:0] direct_out;
    logic [31:0] out;
    logic        push;
    logic        pop;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  index_out;
    logic [3:0]  mono_timer;

    int n_checks = 0;
    int n_fail   = 0;

    csr_timer_stack #(
        .CsrWidth(8), .Addr(12'h300), .ResetValue(0),
        .StackDepth(8), .DataWidth(32), .MonoWidth(4)
    ) dut (
        .clk(clk), .reset(reset),
        .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
        .rs1_zimm(rs1_zimm), .rs1_data(rs1_data),
        .ext_write_enable(ext_write_enable), .ext_data(ext_data),
        .direct_out(direct_out), .out(out),
        .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .index_out(index_out), .mono_timer(mono_timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; csr_enable = 1'b0; csr_addr = 12'h300; csr_op = 3'b000;
        rs1_zimm = '0; rs1_data = '0; ext_write_enable = 1'b0; ext_data = '0;
        push = 1'b0; pop = 1'b0; data_in = '0;
        step(); step();
        check("rst_direct", direct_out, 32'h0);
        check("rst_index", 32'(index_out), 32'h0);
        check("rst_data", data_out, 32'h0);
        check("rst_mono", 32'(mono_timer), 32'h0);
        reset = 1'b0;
        step();
        check("mono_1", 32'(mono_timer), 32'h1);
        step();
        check("mono_2", 32'(mono_timer), 32'h2);

        csr_enable = 1'b1; csr_op = 3'b001; rs1_data = 32'hAB; #1;
        check("rw_out", out, 32'h0);
        step();
        check("rw_direct", direct_out, 32'hAB);
        csr_op = 3'b110; rs1_zimm = 5'h04; #1;
        check("rsi_out", out, 32'hAB);
        step();
        check("rsi_direct", direct_out, 32'hAF);
        csr_op = 3'b111; rs1_zimm = 5'h0F; #1;
        check("rci_out", out, 32'hAF);
        step();
        check("rci_direct", direct_out, 32'hA0);
        csr_addr = 12'h301; csr_op = 3'b001; rs1_data = 32'hFF; #1;
        check("miss_out", out, 32'h0);
        step();
        check("miss_direct", direct_out, 32'hA0);
        csr_addr = 12'h300; csr_op = 3'b100; #1;
        check("nop_out", out, 32'hA0);
        step();
        check("nop_direct", direct_out, 32'hA0);
        csr_op = 3'b010; rs1_data = 32'h0000_0105;
        step();
        check("rs_direct", direct_out, 32'hA5);
        csr_op = 3'b011; rs1_data = 32'h0000_0021;
        step();
        check("rc_direct", direct_out, 32'h84);
        csr_op = 3'b001; rs1_data = 32'h1234;
        step();
        check("trunc", direct_out, 32'h34);
        ext_write_enable = 1'b1; ext_data = 8'h55; rs1_data = 32'h66;
        step();
        check("ext_prio", direct_out, 32'h55);
        ext_write_enable = 1'b0; rs1_data = 32'h77; reset = 1'b1;
        step();
        check("rst_prio_csr", direct_out, 32'h0);
        check("rst_mid_mono", 32'(mono_timer), 32'h0);
        reset = 1'b0; csr_enable = 1'b0; csr_op = 3'b000;
        for (int i = 1; i <= 15; i++) step();
        check("mono_15", 32'(mono_timer), 32'hF);
        step();
        check("mono_wrap", 32'(mono_timer), 32'h0);

        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = 32'(i);
            step();
        end
        check("full_index", 32'(index_out), 32'h8);
        check("full_data", data_out, 32'h8);
        data_in = 32'd9;
        step();
        check("over_index", 32'(index_out), 32'h8);
        check("over_data", data_out, 32'h8);
        push = 1'b0; pop = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("pop_data", data_out, 32'(8 - k));
            check("pop_index", 32'(index_out), 32'(8 - k));
        end
        step();
        check("under_index", 32'(index_out), 32'h0);
        check("under_data", data_out, 32'h0);
        pop = 1'b0; push = 1'b1; data_in = 32'd5;
        step();
        data_in = 32'd6;
        step();
        pop = 1'b1; data_in = 32'd9;
        step();
        check("pp_index", 32'(index_out), 32'h2);
        check("pp_data", data_out, 32'h9);
        push = 1'b0;
        step(); step();
        check("drain_index", 32'(index_out), 32'h0);
        push = 1'b1;
        step();
        check("pp_empty_index", 32'(index_out), 32'h1);
        check("pp_empty_data", data_out, 32'h9);
        pop = 1'b0; reset = 1'b1;
        step();
        check("rst_prio_index", 32'(index_out), 32'h0);
        check("rst_prio_data", data_out, 32'h0);
        reset = 1'b0; push = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
